// File: rtl/comp_gain_loader_if.sv
// Host stream and gain-table signal bundle for comp_gain_loader.
// The master side is the host/downstream; the slave side is the loader.
interface comp_gain_loader_if;
    logic       start;
    logic [7:0] hd;
    logic       hv;
    logic       hrdy;
    logic [7:0] cin;
    logic       cwe;
    logic       mute;
    logic       done;
    logic       err;

    modport master (output start, hd, hv, input hrdy, cin, cwe, mute, done, err);
    modport slave  (input start, hd, hv, output hrdy, cin, cwe, mute, done, err);
endinterface

// File: rtl/comp_gain_loader.sv
// Gain-table loader: unity auto-fill after reset, then host reloads over a valid/ready stream.
// Define COMP_LOADER_CHECKSUM_EN to require a trailing checksum byte on host loads.
//
// state | meaning
// INIT  | shifting UNITY into every entry, host held off
// IDLE  | table complete, waiting for start (or a latched one)
// LOAD  | accepting host bytes, each forwarded to the table one cycle later
// CHECK | checksum verdict after the trailing byte (checksum build only)
module comp_gain_loader #(
    parameter int         ENTRIES = 128,
    parameter logic [7:0] UNITY   = 8'h10,
    parameter int         CW      = 7
) (
    input  logic              clk,
    input  logic              rst,
    comp_gain_loader_if.slave bus
);

`ifdef COMP_LOADER_CHECKSUM_EN
    typedef enum logic [1:0] {S_INIT, S_IDLE, S_LOAD, S_CHECK} state_t;
`else
    typedef enum logic [1:0] {S_INIT, S_IDLE, S_LOAD} state_t;
`endif

    localparam logic [CW-1:0] CNT_LAST = CW'(ENTRIES - 1);
    localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic          pending;
    logic          last_q;
    logic          cwe_q;
    logic          done_q;
    logic          mute_q;
    logic [7:0]    cin_q;
    logic          xfer;
    logic          term;
    logic          load_fin;
    logic          wr_en;
    logic [7:0]    wr_byte;
    logic          fin_set;
`ifdef COMP_LOADER_CHECKSUM_EN
    logic          ck_phase;
    logic          ck_ok;
    logic          err_q;
    logic [7:0]    sum;
    logic [7:0]    sum_nxt;
`endif

    assign xfer = (state == S_LOAD) && bus.hv;
    assign term = (cnt == CNT_LAST);

`ifdef COMP_LOADER_CHECKSUM_EN
    assign sum_nxt  = sum + bus.hd;
    assign load_fin = xfer && ck_phase;
`else
    assign load_fin = xfer && term;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_INIT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_INIT:  if (term) state_nxt = S_IDLE;
            S_IDLE:  if (bus.start || pending) state_nxt = S_LOAD;
`ifdef COMP_LOADER_CHECKSUM_EN
            S_LOAD:  if (load_fin) state_nxt = S_CHECK;
            S_CHECK: state_nxt = ck_ok ? S_IDLE : S_INIT;
`else
            S_LOAD:  if (load_fin) state_nxt = S_IDLE;
`endif
            default: state_nxt = S_INIT;
        endcase
    end

    // fin_set marks the cycle whose successor carries the last cwe; done follows one cycle later.
    always_comb begin
        wr_en   = 1'b0;
        wr_byte = UNITY;
        fin_set = 1'b0;
        case (state)
            S_INIT: begin
                wr_en   = 1'b1;
                fin_set = term;
            end
`ifdef COMP_LOADER_CHECKSUM_EN
            S_LOAD: begin
                wr_en   = xfer && !ck_phase;
                wr_byte = bus.hd;
            end
            S_CHECK: fin_set = ck_ok;
`else
            S_LOAD: begin
                wr_en   = xfer;
                wr_byte = bus.hd;
                fin_set = load_fin;
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            pending <= 1'b0;
            last_q  <= 1'b0;
            cwe_q   <= 1'b0;
            done_q  <= 1'b0;
            mute_q  <= 1'b1;
            cin_q   <= 8'h00;
`ifdef COMP_LOADER_CHECKSUM_EN
            ck_phase <= 1'b0;
            ck_ok    <= 1'b0;
            err_q    <= 1'b0;
            sum      <= 8'h00;
`endif
        end else begin
            cwe_q  <= wr_en;
            last_q <= fin_set;
            done_q <= last_q;
            if (wr_en) cin_q <= wr_byte;
            if (last_q) mute_q <= 1'b0;
            case (state)
                S_INIT: begin
                    cnt <= term ? '0 : cnt + 1'b1;
                    if (bus.start) pending <= 1'b1;
                end
                S_IDLE: begin
                    if (bus.start || pending) begin
                        cnt     <= '0;
                        pending <= 1'b0;
                        mute_q  <= 1'b1;
`ifdef COMP_LOADER_CHECKSUM_EN
                        err_q    <= 1'b0;
                        sum      <= 8'h00;
                        ck_phase <= 1'b0;
`endif
                    end
                end
                S_LOAD: begin
                    // A restart that coincides with a transfer keeps that byte as entry 0 of the new load.
                    if (bus.start && !load_fin) begin
                        cnt <= xfer ? CNT_ONE : '0;
`ifdef COMP_LOADER_CHECKSUM_EN
                        sum      <= xfer ? bus.hd : 8'h00;
                        ck_phase <= 1'b0;
`endif
                    end else begin
                        if (bus.start) pending <= 1'b1;
                        if (xfer) begin
`ifdef COMP_LOADER_CHECKSUM_EN
                            if (ck_phase) begin
                                ck_phase <= 1'b0;
                                ck_ok    <= (sum_nxt == 8'h00);
                            end else begin
                                sum <= sum_nxt;
                                cnt <= term ? '0 : cnt + 1'b1;
                                if (term) ck_phase <= 1'b1;
                            end
`else
                            cnt <= term ? '0 : cnt + 1'b1;
`endif
                        end
                    end
                end
`ifdef COMP_LOADER_CHECKSUM_EN
                S_CHECK: begin
                    if (bus.start) pending <= 1'b1;
                    if (!ck_ok) err_q <= 1'b1;
                end
`endif
                default: ;
            endcase
        end
    end

    assign bus.hrdy = (state == S_LOAD);
    assign bus.cin  = cin_q;
    assign bus.cwe  = cwe_q;
    assign bus.mute = mute_q;
    assign bus.done = done_q;
`ifdef COMP_LOADER_CHECKSUM_EN
    assign bus.err  = err_q;
`else
    assign bus.err  = 1'b0;
`endif

endmodule

// File: tb/tb_comp_gain_loader.sv
// Bench for comp_gain_loader: stimulus queues the expected cin byte of every table write,
// and an independent monitor pops and checks one entry per observed cwe.
`timescale 1ns/1ps
module tb_comp_gain_loader;
    localparam int         ENTRIES = 128;
    localparam logic [7:0] UNITY   = 8'h10;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] exp_q[$];
    int         cwe_cnt = 0;
    int         done_cnt = 0;
    int         run = 0;
    int         last_run = 0;
    logic [7:0] ld_sum;

    comp_gain_loader_if bus();

    comp_gain_loader #(.ENTRIES(ENTRIES), .UNITY(UNITY), .CW(7)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // monitor: outputs settle after posedge, sampled on the falling edge
    always @(negedge clk) begin
        if (bus.cwe === 1'b1) begin
            cwe_cnt++;
            run++;
            chk("mute_during_cwe", {31'd0, bus.mute}, 1);
            chk("cwe_has_expected_entry", {31'd0, exp_q.size() != 0}, 1);
            if (exp_q.size() != 0) chk("cin", {24'd0, bus.cin}, {24'd0, exp_q.pop_front()});
        end else begin
            if (run != 0) last_run = run;
            run = 0;
        end
        if (bus.done === 1'b1) done_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input string name);
        int t;
        t = 0;
        while (bus.done !== 1'b1 && t < 2000) begin
            tick();
            t++;
        end
        chk(name, {31'd0, t < 2000}, 1);
    endtask

    task automatic send(input logic [7:0] b, input bit gap, input bit fwd);
        int t;
        t = 0;
        bus.hd = b;
        bus.hv = 1'b1;
        while (bus.hrdy !== 1'b1 && t < 2000) begin
            tick();
            t++;
        end
        chk("hrdy_for_send", {31'd0, bus.hrdy}, 1);
        if (fwd) begin
            exp_q.push_back(b);
            ld_sum = ld_sum + b;
        end
        tick();
        bus.hv = 1'b0;
        if (gap) tick();
    endtask

    task automatic stream(input int n, input int base, input int step, input int gapmod);
        logic [7:0] v;
        for (int i = 0; i < n; i++) begin
            v = 8'(base + step * i);
            send(v, (gapmod != 0) && (i % gapmod == 0), 1'b1);
        end
    endtask

    task automatic finish_load();
`ifdef COMP_LOADER_CHECKSUM_EN
        send(8'h00 - ld_sum, 1'b0, 1'b0);
`endif
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        ld_sum = 8'h00;
    endtask

    task automatic push_unity();
        for (int i = 0; i < ENTRIES; i++) exp_q.push_back(UNITY);
    endtask

    initial begin
        int c0;
        int d0;
        int t;
        bus.start = 1'b0;
        bus.hv    = 1'b0;
        bus.hd    = 8'h00;
        ld_sum    = 8'h00;
        rst       = 1'b1;
        repeat (3) tick();

        chk("rst_hrdy", {31'd0, bus.hrdy}, 0);
        chk("rst_cwe",  {31'd0, bus.cwe},  0);
        chk("rst_cin",  {24'd0, bus.cin},  0);
        chk("rst_mute", {31'd0, bus.mute}, 1);
        chk("rst_done", {31'd0, bus.done}, 0);
        chk("rst_err",  {31'd0, bus.err},  0);

        // reset auto-load
        c0 = cwe_cnt; d0 = done_cnt;
        push_unity();
        rst = 1'b0;
        wait_done("init_done_seen");
        tick(); tick();
        chk("init_cwe_count", cwe_cnt - c0, 128);
        chk("init_cwe_consecutive", last_run, 128);
        chk("init_done_count", done_cnt - d0, 1);
        chk("init_mute_after", {31'd0, bus.mute}, 0);
        chk("init_hrdy_idle", {31'd0, bus.hrdy}, 0);
        chk("init_queue_drained", exp_q.size(), 0);

        // host load 7F..00 with hv toggling
        c0 = cwe_cnt; d0 = done_cnt;
        pulse_start();
        chk("load_hrdy", {31'd0, bus.hrdy}, 1);
        chk("load_mute", {31'd0, bus.mute}, 1);
        stream(128, 127, -1, 1);
        finish_load();
        chk("load_hrdy_after_last", {31'd0, bus.hrdy}, 0);
        wait_done("load_done_seen");
        tick(); tick();
        chk("load_cwe_count", cwe_cnt - c0, 128);
        chk("load_done_count", done_cnt - d0, 1);
        chk("load_mute_after", {31'd0, bus.mute}, 0);
        chk("load_queue_drained", exp_q.size(), 0);

        // start on the 5th INIT cycle is latched
        rst = 1'b1;
        tick(); tick();
        c0 = cwe_cnt; d0 = done_cnt;
        push_unity();
        rst = 1'b0;
        repeat (4) tick();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        t = 0;
        while (bus.hrdy !== 1'b1 && t < 400) begin
            tick();
            t++;
        end
        chk("pending_load_hrdy", {31'd0, bus.hrdy}, 1);
        chk("pending_wait_cycles", t, 124);
        tick();
        chk("pending_init_cwe", cwe_cnt - c0, 128);
        chk("pending_init_done", done_cnt - d0, 1);
        chk("pending_mute", {31'd0, bus.mute}, 1);

        // restart after 60 bytes
        c0 = cwe_cnt; d0 = done_cnt;
        ld_sum = 8'h00;
        stream(60, 1, 5, 0);
        pulse_start();
        chk("restart_mute", {31'd0, bus.mute}, 1);
        chk("restart_hrdy", {31'd0, bus.hrdy}, 1);
        stream(128, 200, -3, 3);
        finish_load();
        wait_done("restart_done_seen");
        tick(); tick();
        chk("restart_cwe_count", cwe_cnt - c0, 188);
        chk("restart_done_count", done_cnt - d0, 1);
        chk("restart_mute_after", {31'd0, bus.mute}, 0);
        chk("restart_queue_drained", exp_q.size(), 0);

        // reset in the middle of a host load
        pulse_start();
        stream(40, 9, 7, 0);
        tick();
        c0 = cwe_cnt; d0 = done_cnt;
        push_unity();
        rst = 1'b1;
        bus.hv = 1'b1;
        bus.hd = 8'hEE;
        tick(); tick();
        chk("rstmid_hrdy", {31'd0, bus.hrdy}, 0);
        chk("rstmid_mute", {31'd0, bus.mute}, 1);
        chk("rstmid_cwe",  {31'd0, bus.cwe},  0);
        rst = 1'b0;
        wait_done("rstmid_done_seen");
        repeat (3) tick();
        chk("rstmid_cwe_count", cwe_cnt - c0, 128);
        chk("rstmid_cwe_consecutive", last_run, 128);
        chk("rstmid_done_count", done_cnt - d0, 1);
        chk("rstmid_hrdy_idle", {31'd0, bus.hrdy}, 0);
        chk("rstmid_queue_drained", exp_q.size(), 0);
        bus.hv = 1'b0;

`ifdef COMP_LOADER_CHECKSUM_EN
        pulse_start();
        stream(128, 1, 0, 0);
        send(8'h80, 1'b0, 1'b0);
        wait_done("ck_pass_done_seen");
        tick();
        chk("ck_pass_err", {31'd0, bus.err}, 0);
        chk("ck_pass_mute", {31'd0, bus.mute}, 0);

        pulse_start();
        stream(128, 1, 0, 0);
        send(8'h81, 1'b0, 1'b0);
        c0 = cwe_cnt;
        push_unity();
        tick(); tick();
        chk("ck_fail_err", {31'd0, bus.err}, 1);
        chk("ck_fail_mute", {31'd0, bus.mute}, 1);
        wait_done("ck_refill_done_seen");
        tick(); tick();
        chk("ck_refill_cwe_count", cwe_cnt - c0, 128);
        chk("ck_refill_consecutive", last_run, 128);
        chk("ck_err_sticky", {31'd0, bus.err}, 1);
        chk("ck_refill_mute_after", {31'd0, bus.mute}, 0);
        pulse_start();
        chk("ck_err_cleared", {31'd0, bus.err}, 0);
`else
        chk("err_tied_low", {31'd0, bus.err}, 0);
`endif

        repeat (3) tick();
        chk("final_queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end

endmodule
